// File: rtl/addr_decoder_gen2.sv
// Host-to-switch address decoder: per-switch request queues, round-robin issue on a
// shared switch bus, per-switch outstanding tracking with timeout, tagged completions.

module addr_decoder_gen2_sw #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15,
  parameter int ENT_W      = 1 + ADDR_W + DATA_W + ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ENT_W-1:0]  push_ent,
  input  logic              grant,
  input  logic              ack,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              cmpl_grant,
  output logic              full,
  output logic              req,
  output logic              hd_wr,
  output logic [ADDR_W-1:0] hd_addr,
  output logic [DATA_W-1:0] hd_data,
  output logic              cand,
  output logic [DATA_W-1:0] cand_data,
  output logic              cand_err,
  output logic [ID_W-1:0]   cand_id
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUED = 2'd1, S_RESP = 2'd2;

  logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, pop, store;
  logic [ENT_W-1:0]  head;
  logic [1:0]        state;
  logic [TW-1:0]     tmr;
  logic              wr_q, err_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] rdat_q;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  // An empty queue hands the incoming entry straight to the arbiter; it is only stored if not issued.
  assign head  = empty ? push_ent : mem[rd_ptr];
  assign pop   = grant & ~empty;
  assign store = push & ~(empty & grant);
  assign req   = (state == S_IDLE) & (~empty | push);

  assign hd_wr   = head[ENT_W-1];
  assign hd_addr = head[ENT_W-2 -: ADDR_W];
  assign hd_data = head[ID_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tmr    <= '0;
      wr_q   <= 1'b0;
      id_q   <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (grant) begin
          state <= S_ISSUED;
          tmr   <= T_LOAD;
          wr_q  <= head[ENT_W-1];
          id_q  <= head[ID_W-1:0];
        end
        S_ISSUED: if (ack) begin
          // An ack delivered in its own cycle skips RESP entirely.
          state  <= cmpl_grant ? S_IDLE : S_RESP;
          rdat_q <= wr_q ? '0 : rd_data;
          err_q  <= 1'b0;
        end else if (tmr == '0) begin
          state  <= S_RESP;
          rdat_q <= '0;
          err_q  <= 1'b1;
        end else begin
          tmr <= tmr - TW'(1);
        end
        S_RESP:  if (cmpl_grant) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cand      = (state == S_RESP) | ((state == S_ISSUED) & ack);
  assign cand_data = (state == S_RESP) ? rdat_q : (wr_q ? '0 : rd_data);
  assign cand_err  = (state == S_RESP) & err_q;
  assign cand_id   = id_q;
endmodule

module addr_decoder_gen2 #(
  parameter int NUM_SW     = 5,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic                     wr_rd_op,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [ID_W-1:0]          op_id_in,
  input  logic [DATA_W-1:0]        wr_data_in,
  output logic [NUM_SW-1:0]        sel_en_out,
  output logic                     wr_rd_s_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [DATA_W-1:0]        wr_data_out,
  input  logic [NUM_SW-1:0]        ack_in,
  input  logic [NUM_SW*DATA_W-1:0] rd_data_in,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_op_id,
  output logic [DATA_W-1:0]        rd_data_out,
  output logic                     done_err
);
  localparam int IDX_W = $clog2(NUM_SW);
  localparam int ENT_W = 1 + ADDR_W + DATA_W + ID_W;
  localparam logic [IDX_W:0] NSW = (IDX_W+1)'(NUM_SW);

  logic [IDX_W-1:0] idx, rr_ptr, win;
  logic             mapped, tgt_full, accept, err_acc, any_iss;
  logic [NUM_SW-1:0] full, req, push, grant, cand, cand_err, cmpl_grant, hd_wr;
  logic [NUM_SW-1:0][ADDR_W-1:0] hd_addr;
  logic [NUM_SW-1:0][DATA_W-1:0] hd_data, cand_data;
  logic [NUM_SW-1:0][ID_W-1:0]   cand_id;
  logic              c_vld, c_err;
  logic [ID_W-1:0]   c_id;
  logic [DATA_W-1:0] c_data;

  assign idx    = addr_in[ADDR_W-1 -: IDX_W];
  assign mapped = ({1'b0, idx} < NSW);

  always_comb begin
    tgt_full = 1'b0;
    for (int i = 0; i < NUM_SW; i++)
      if (idx == IDX_W'(i)) tgt_full = full[i];
  end

  // Unmapped requests complete at their accept edge on the top-priority error path,
  // so the one-entry error slot is always free again by the next cycle.
  assign ready_out = mapped ? ~tgt_full : 1'b1;
  assign accept    = valid_in & ready_out;
  assign err_acc   = accept & ~mapped;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    assign push[i] = accept & mapped & (idx == IDX_W'(i));
    addr_decoder_gen2_sw #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .ENT_W(ENT_W)
    ) u_sw (
      .clk(clk), .rst(rst), .push(push[i]),
      .push_ent({wr_rd_op, addr_in, wr_data_in, op_id_in}),
      .grant(grant[i]), .ack(ack_in[i]), .rd_data(rd_data_in[i*DATA_W +: DATA_W]),
      .cmpl_grant(cmpl_grant[i]), .full(full[i]), .req(req[i]),
      .hd_wr(hd_wr[i]), .hd_addr(hd_addr[i]), .hd_data(hd_data[i]),
      .cand(cand[i]), .cand_data(cand_data[i]), .cand_err(cand_err[i]), .cand_id(cand_id[i])
    );
  end

  always_comb begin : p_iss_arb
    int j;
    j       = 0;
    grant   = '0;
    win     = '0;
    any_iss = 1'b0;
    for (int k = 0; k < NUM_SW; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SW) j = j - NUM_SW;
      if (!any_iss && req[j]) begin
        any_iss  = 1'b1;
        win      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      sel_en_out  <= '0;
      wr_rd_s_out <= 1'b0;
      addr_out    <= '0;
      wr_data_out <= '0;
    end else begin
      sel_en_out  <= grant;
      wr_rd_s_out <= any_iss & hd_wr[win];
      addr_out    <= any_iss ? hd_addr[win] : '0;
      wr_data_out <= any_iss ? hd_data[win] : '0;
      if (any_iss) rr_ptr <= (win == IDX_W'(NUM_SW - 1)) ? '0 : win + IDX_W'(1);
    end
  end

  always_comb begin
    cmpl_grant = '0;
    c_vld      = 1'b0;
    c_err      = 1'b0;
    c_id       = '0;
    c_data     = '0;
    if (err_acc) begin
      c_vld = 1'b1;
      c_err = 1'b1;
      c_id  = op_id_in;
    end else begin
      for (int i = 0; i < NUM_SW; i++)
        if (!c_vld && cand[i]) begin
          c_vld         = 1'b1;
          cmpl_grant[i] = 1'b1;
          c_id          = cand_id[i];
          c_data        = cand_data[i];
          c_err         = cand_err[i];
        end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid  <= 1'b0;
      done_op_id  <= '0;
      rd_data_out <= '0;
      done_err    <= 1'b0;
    end else begin
      done_valid  <= c_vld;
      done_op_id  <= c_id;
      rd_data_out <= c_data;
      done_err    <= c_err;
    end
  end
endmodule

// File: tb/tb_addr_decoder_gen2.sv
// Scoreboard bench for addr_decoder_gen2: stimulus queues expected issues/completions,
// a negedge monitor pops and compares them whenever the DUT pulses an output.

module tb_addr_decoder_gen2;
  localparam int NUM_SW = 5;

  logic clk, rst, valid_in, ready_out, wr_rd_op, wr_rd_s_out, done_valid, done_err;
  logic [7:0] addr_in, op_id_in, wr_data_in, addr_out, wr_data_out, done_op_id, rd_data_out;
  logic [NUM_SW-1:0] sel_en_out, ack_in;
  logic [NUM_SW*8-1:0] rd_data_in;

  addr_decoder_gen2 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .wr_rd_op(wr_rd_op),
    .addr_in(addr_in), .op_id_in(op_id_in), .wr_data_in(wr_data_in), .sel_en_out(sel_en_out),
    .wr_rd_s_out(wr_rd_s_out), .addr_out(addr_out), .wr_data_out(wr_data_out), .ack_in(ack_in),
    .rd_data_in(rd_data_in), .done_valid(done_valid), .done_op_id(done_op_id),
    .rd_data_out(rd_data_out), .done_err(done_err)
  );

  typedef struct { logic [4:0] sel; logic wr; logic [7:0] addr; logic [7:0] data; int cyc; } iss_t;
  typedef struct { logic [7:0] id; logic [7:0] data; logic err; int cyc; } dn_t;

  iss_t iss_q[$];
  dn_t  dn_q[$];
  int   nchk = 0, nerr = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    iss_t ei;
    dn_t  ed;
    if (!rst) begin
      nchk++;
      if (sel_en_out != '0) begin
        if (iss_q.size() == 0) begin
          nerr++;
          $display("FAIL issue: unexpected sel=%b addr=%h at cyc %0d", sel_en_out, addr_out, cyc);
        end else begin
          ei = iss_q.pop_front();
          if (sel_en_out !== ei.sel || wr_rd_s_out !== ei.wr || addr_out !== ei.addr ||
              wr_data_out !== ei.data || cyc != ei.cyc) begin
            nerr++;
            $display("FAIL issue: got sel=%b wr=%b addr=%h data=%h cyc=%0d expected sel=%b wr=%b addr=%h data=%h cyc=%0d",
                     sel_en_out, wr_rd_s_out, addr_out, wr_data_out, cyc, ei.sel, ei.wr, ei.addr, ei.data, ei.cyc);
          end
        end
      end else if ({wr_rd_s_out, addr_out, wr_data_out} !== '0) begin
        nerr++;
        $display("FAIL idle_bus: got wr=%b addr=%h data=%h expected all 0", wr_rd_s_out, addr_out, wr_data_out);
      end
      nchk++;
      if (done_valid) begin
        if (dn_q.size() == 0) begin
          nerr++;
          $display("FAIL done: unexpected id=%h err=%b at cyc %0d", done_op_id, done_err, cyc);
        end else begin
          ed = dn_q.pop_front();
          if (done_op_id !== ed.id || rd_data_out !== ed.data || done_err !== ed.err || cyc != ed.cyc) begin
            nerr++;
            $display("FAIL done: got id=%h data=%h err=%b cyc=%0d expected id=%h data=%h err=%b cyc=%0d",
                     done_op_id, rd_data_out, done_err, cyc, ed.id, ed.data, ed.err, ed.cyc);
          end
        end
      end else if ({done_op_id, rd_data_out, done_err} !== '0) begin
        nerr++;
        $display("FAIL idle_done: got id=%h data=%h err=%b expected all 0", done_op_id, rd_data_out, done_err);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] id,
                     input logic [7:0] d, output int acc);
    valid_in = 1'b1; wr_rd_op = wr; addr_in = a; op_id_in = id; wr_data_in = d;
    #1 chk("ready", ready_out, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    acc = cyc;
  endtask

  task automatic ack(input logic [4:0] m, input logic [39:0] rd);
    ack_in = m; rd_data_in = rd;
    @(posedge clk); #1;
    ack_in = '0; rd_data_in = '0;
  endtask

  task automatic exp_iss(input logic [4:0] s, input logic w, input logic [7:0] a, input logic [7:0] d, input int c);
    iss_t e;
    e.sel = s; e.wr = w; e.addr = a; e.data = d; e.cyc = c;
    iss_q.push_back(e);
  endtask

  task automatic exp_dn(input logic [7:0] id, input logic [7:0] d, input logic er, input int c);
    dn_t e;
    e.id = id; e.data = d; e.err = er; e.cyc = c;
    dn_q.push_back(e);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_sel"}, sel_en_out, 0);
    chk({nm, "_bus"}, {wr_rd_s_out, addr_out, wr_data_out}, 0);
    chk({nm, "_done"}, {done_valid, done_op_id, rd_data_out, done_err}, 0);
  endtask

  initial begin
    int a, k;
    rst = 1'b1; valid_in = 1'b0; wr_rd_op = 1'b0; addr_in = '0; op_id_in = '0;
    wr_data_in = '0; ack_in = '0; rd_data_in = '0;
    idle(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    idle(1);
    chk("ready_after_reset", ready_out, 1'b1);

    // write to switch 2, then ack
    req(1'b1, 8'h41, 8'h11, 8'h3C, a); exp_iss(5'b00100, 1'b1, 8'h41, 8'h3C, a);
    k = cyc; exp_dn(8'h11, 8'h00, 1'b0, k + 1); ack(5'b00100, 40'hFF_FF_FF_FF_FF);
    idle(2);

    // read from switch 0 returns its rd_data slice
    req(1'b0, 8'h00, 8'h07, 8'h00, a); exp_iss(5'b00001, 1'b0, 8'h00, 8'h00, a);
    k = cyc; exp_dn(8'h07, 8'hA5, 1'b0, k + 1); ack(5'b00001, 40'h00_00_00_00_A5);
    idle(2);

    // switch 1: one outstanding, two queued, fourth blocked; switch 3 still accepted
    req(1'b1, 8'h20, 8'h21, 8'hB1, a); exp_iss(5'b00010, 1'b1, 8'h20, 8'hB1, a);
    req(1'b1, 8'h24, 8'h22, 8'hB2, a);
    req(1'b1, 8'h28, 8'h23, 8'hB3, a);
    valid_in = 1'b1; wr_rd_op = 1'b1; addr_in = 8'h2C; op_id_in = 8'h24; wr_data_in = 8'hB4;
    #1 chk("ready_full_q", ready_out, 1'b0);
    addr_in = 8'h60; op_id_in = 8'h31; wr_data_in = 8'hC3;
    #1 chk("ready_other_q", ready_out, 1'b1);
    @(posedge clk); #1; valid_in = 1'b0; a = cyc;
    exp_iss(5'b01000, 1'b1, 8'h60, 8'hC3, a);
    k = cyc; exp_dn(8'h21, 8'h00, 1'b0, k + 1); exp_iss(5'b00010, 1'b1, 8'h24, 8'hB2, k + 2);
    ack(5'b00010, 40'h0); idle(2);
    k = cyc; exp_dn(8'h22, 8'h00, 1'b0, k + 1); exp_iss(5'b00010, 1'b1, 8'h28, 8'hB3, k + 2);
    ack(5'b00010, 40'h0); idle(2);
    k = cyc; exp_dn(8'h23, 8'h00, 1'b0, k + 1); ack(5'b00010, 40'h0); idle(1);
    k = cyc; exp_dn(8'h31, 8'h00, 1'b0, k + 1); ack(5'b01000, 40'h0); idle(2);

    // switches 0,1,3 busy with one queued each; simultaneous acks
    req(1'b0, 8'h00, 8'h40, 8'h00, a); exp_iss(5'b00001, 1'b0, 8'h00, 8'h00, a);
    req(1'b0, 8'h20, 8'h41, 8'h00, a); exp_iss(5'b00010, 1'b0, 8'h20, 8'h00, a);
    req(1'b0, 8'h60, 8'h43, 8'h00, a); exp_iss(5'b01000, 1'b0, 8'h60, 8'h00, a);
    req(1'b0, 8'h04, 8'h50, 8'h00, a);
    req(1'b0, 8'h24, 8'h51, 8'h00, a);
    req(1'b0, 8'h64, 8'h53, 8'h00, a);
    k = cyc;
    exp_dn(8'h40, 8'h10, 1'b0, k + 1); exp_dn(8'h41, 8'h11, 1'b0, k + 2); exp_dn(8'h43, 8'h13, 1'b0, k + 3);
    exp_iss(5'b00001, 1'b0, 8'h04, 8'h00, k + 2);
    exp_iss(5'b00010, 1'b0, 8'h24, 8'h00, k + 3);
    exp_iss(5'b01000, 1'b0, 8'h64, 8'h00, k + 4);
    ack(5'b01011, 40'h00_13_00_11_10);
    idle(5);
    k = cyc; exp_dn(8'h51, 8'h21, 1'b0, k + 1); exp_dn(8'h53, 8'h23, 1'b0, k + 2);
    ack(5'b01010, 40'h00_23_00_21_00);
    idle(3);
    k = cyc; exp_dn(8'h50, 8'h20, 1'b0, k + 1); ack(5'b00001, 40'h00_00_00_00_20);
    idle(2);

    // unmapped addresses complete with error, no issue
    req(1'b1, 8'hE0, 8'hEE, 8'h77, a); exp_dn(8'hEE, 8'h00, 1'b1, a);
    idle(1);
    req(1'b0, 8'hA0, 8'hEF, 8'h00, a); exp_dn(8'hEF, 8'h00, 1'b1, a);
    idle(1);

    // timeout, then ack arriving in the expiry cycle
    req(1'b0, 8'h80, 8'h44, 8'h00, a); exp_iss(5'b10000, 1'b0, 8'h80, 8'h00, a);
    exp_dn(8'h44, 8'h00, 1'b1, a + 16);
    idle(20);
    req(1'b0, 8'h84, 8'h45, 8'h00, a); exp_iss(5'b10000, 1'b0, 8'h84, 8'h00, a);
    idle(14);
    exp_dn(8'h45, 8'h5A, 1'b0, a + 15); ack(5'b10000, 40'h5A_00_00_00_00);
    idle(2);
    ack(5'b00100, 40'h00_00_FF_00_00);
    idle(2);

    // reset while switch 4 outstanding with two queued
    req(1'b1, 8'h80, 8'h60, 8'hD0, a); exp_iss(5'b10000, 1'b1, 8'h80, 8'hD0, a);
    req(1'b1, 8'h84, 8'h61, 8'hD1, a);
    req(1'b1, 8'h88, 8'h62, 8'hD2, a);
    rst = 1'b1;
    #1 chk_outs_zero("mid_reset");
    idle(2);
    chk_outs_zero("mid_reset_held");
    rst = 1'b0;
    idle(1);
    ack(5'b10000, 40'h99_00_00_00_00);
    idle(2);
    req(1'b1, 8'h8C, 8'h63, 8'hD3, a); exp_iss(5'b10000, 1'b1, 8'h8C, 8'hD3, a);
    k = cyc; exp_dn(8'h63, 8'h00, 1'b0, k + 1); ack(5'b10000, 40'h0);
    idle(20);

    chk("issue_q_drained", iss_q.size(), 0);
    chk("done_q_drained", dn_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
